// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution window controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  localparam int CONV_K_DEF       = 5;
  localparam int CONV_PIXEL_W_DEF = 8;
  localparam int CONV_MAX_W_DEF   = 1920;
  localparam int CONV_MAX_H_DEF   = 1080;
  localparam int CONV_COL_W_DEF   = $clog2(CONV_MAX_W_DEF);

  typedef logic [CONV_PIXEL_W_DEF-1:0] pixel_t;

  // Bit offsets of the fields inside pos_o. The row field sits directly above
  // the column field, so its LSB moves with COL_W; the default-width value is
  // listed for reference.
  typedef enum int {
    POS_LAST_COL_BIT  = 0,
    POS_FIRST_COL_BIT = 1,
    POS_COL_LSB       = 2,
    POS_ROW_LSB_DEF   = 2 + CONV_COL_W_DEF
  } conv_win_pos_field_e;

endpackage

// File: rtl/conv_lb_ring.sv
// Line-buffer ring: one-hot write pointer plus a mask of lines already resident.
// Latency: we_o/re_o reflect the input beat one cycle later (registered).
// Backpressure: none; every valid beat is consumed.
module conv_lb_ring
  import conv_pkg::*;
#(
  parameter int K = CONV_K_DEF
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         vld_i,
  input  logic         sof_i,
  input  logic         eol_i,
  output logic [K-1:0] we_o,
  output logic [K-1:0] re_o
);

  logic [K-1:0] wr_ptr_q, wr_ptr_d;
  logic [K-1:0] fill_q, fill_d;
  logic [K-1:0] we_q, we_d;
  logic [K-1:0] re_q, re_d;
  logic [K-1:0] beat_ptr, beat_fill, next_ptr;

  // Pointer/fill update: sof restarts the ring, eol retires the current line
  // and frees the buffer the pointer is about to overwrite.
  always_comb begin
    beat_ptr  = sof_i ? K'(1) : wr_ptr_q;
    beat_fill = sof_i ? '0 : fill_q;
    next_ptr  = {beat_ptr[K-2:0], beat_ptr[K-1]};
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    we_d      = '0;
    re_d      = '0;
    if (vld_i) begin
      we_d = beat_ptr;
      re_d = beat_fill & ~beat_ptr;
      if (eol_i) begin
        wr_ptr_d = next_ptr;
        fill_d   = (beat_fill | beat_ptr) & ~next_ptr;
      end else begin
        wr_ptr_d = beat_ptr;
        fill_d   = beat_fill;
      end
    end
  end

  // Ring state and registered enables.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= K'(1);
      fill_q   <= '0;
      we_q     <= '0;
      re_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      we_q     <= we_d;
      re_q     <= re_d;
    end
  end

  assign we_o = we_q;
  assign re_o = re_q;

endmodule

// File: rtl/conv_win_cntrl.sv
// KxK window controller: tracks row/col of a raster stream, drives LB enables.
// Latency: all outputs reflect the input beat of cycle N in cycle N+1.
// Backpressure: none. Optional line-length check: CONV_WIN_CNTRL_LINE_CHECK_EN.
module conv_win_cntrl
  import conv_pkg::*;
#(
  parameter  int K       = CONV_K_DEF,
  parameter  int PIXEL_W = CONV_PIXEL_W_DEF,
  parameter  int MAX_W   = CONV_MAX_W_DEF,
  parameter  int MAX_H   = CONV_MAX_H_DEF,
  localparam int COL_W   = $clog2(MAX_W),
  localparam int ROW_W   = $clog2(MAX_H),
  localparam int POS_W   = ROW_W + COL_W + 2
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               intf_vld_i,
  input  logic               intf_sof_i,
  input  logic               intf_eol_i,
  input  logic [PIXEL_W-1:0] intf_dat_i,
  output logic               pos_vld_o,
  output logic [POS_W-1:0]   pos_o,
  output logic               lbx_nl_o,
  output logic [K-1:0]       lbx_we_o,
  output logic [K-1:0]       lbx_re_o,
  output logic [PIXEL_W-1:0] lb0_dat_o,
  output logic               err_o
);

  localparam int               ROW_LSB = POS_COL_LSB + COL_W;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(MAX_H - 1);
  localparam logic [COL_W-1:0] COL_WIN = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_WIN = ROW_W'(K - 1);

  logic [COL_W-1:0] col_q, col_d, beat_col;
  logic [ROW_W-1:0] row_q, row_d, beat_row;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             pos_vld_q, pos_vld_d;
  logic             nl_q, nl_d;

  // Coordinates of the current beat; sof pins it to (0,0) whatever came before.
  always_comb begin
    beat_col = intf_sof_i ? '0 : col_q;
    beat_row = intf_sof_i ? '0 : row_q;
  end

  // Counter advance and window-position beat; both counters saturate.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    pos_d     = pos_q;
    pos_vld_d = 1'b0;
    nl_d      = 1'b0;
    if (intf_vld_i) begin
      if (intf_eol_i)              col_d = '0;
      else if (beat_col != COL_MAX) col_d = beat_col + 1'b1;
      else                         col_d = beat_col;
      if (intf_eol_i && (beat_row != ROW_MAX)) row_d = beat_row + 1'b1;
      else                                     row_d = beat_row;
      pos_vld_d                       = (beat_row >= ROW_WIN) && (beat_col >= COL_WIN);
      nl_d                            = intf_eol_i;
      pos_d[POS_LAST_COL_BIT]         = intf_eol_i;
      pos_d[POS_FIRST_COL_BIT]        = (beat_col == COL_WIN);
      pos_d[POS_COL_LSB +: COL_W]     = beat_col;
      pos_d[ROW_LSB +: ROW_W]         = beat_row;
    end
  end

  // Position counters and registered window outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      pos_q     <= '0;
      pos_vld_q <= 1'b0;
      nl_q      <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      pos_q     <= pos_d;
      pos_vld_q <= pos_vld_d;
      nl_q      <= nl_d;
    end
  end

  assign pos_vld_o = pos_vld_q;
  assign pos_o     = pos_q;
  assign lbx_nl_o  = nl_q;

  conv_lb_ring #(.K(K)) u_lb_ring (
    .clk    (clk),
    .arst_n (arst_n),
    .vld_i  (intf_vld_i),
    .sof_i  (intf_sof_i),
    .eol_i  (intf_eol_i),
    .we_o   (lbx_we_o),
    .re_o   (lbx_re_o)
  );

  generate
    if (PIXEL_W == CONV_PIXEL_W_DEF) begin : g_dat_pix
      pixel_t lb0_dat_q, lb0_dat_d;
      // Capture pixel on valid beats, hold across idle cycles.
      always_comb lb0_dat_d = intf_vld_i ? intf_dat_i : lb0_dat_q;
      // Write-data register.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) lb0_dat_q <= '0;
        else         lb0_dat_q <= lb0_dat_d;
      end
      assign lb0_dat_o = lb0_dat_q;
    end else begin : g_dat_gen
      logic [PIXEL_W-1:0] lb0_dat_q, lb0_dat_d;
      // Capture pixel on valid beats, hold across idle cycles.
      always_comb lb0_dat_d = intf_vld_i ? intf_dat_i : lb0_dat_q;
      // Write-data register.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) lb0_dat_q <= '0;
        else         lb0_dat_q <= lb0_dat_d;
      end
      assign lb0_dat_o = lb0_dat_q;
    end
  endgenerate

`ifdef CONV_WIN_CNTRL_LINE_CHECK_EN
  logic [COL_W:0] width_q, width_d, beat_len;
  logic           err_q, err_d;

  // Row 0 sets the reference width; later lines must match it, and a line
  // running past the column limit is always an error. sof starts afresh.
  always_comb begin
    width_d  = width_q;
    err_d    = err_q;
    beat_len = {1'b0, beat_col} + 1'b1;
    if (intf_vld_i) begin
      if (intf_sof_i) err_d = 1'b0;
      if (intf_eol_i) begin
        if (beat_row == '0)          width_d = beat_len;
        else if (beat_len != width_q) err_d   = 1'b1;
      end else if (beat_col == COL_MAX) begin
        err_d = 1'b1;
      end
    end
  end

  // Reference width and sticky error flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      width_q <= '0;
      err_q   <= 1'b0;
    end else begin
      width_q <= width_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_conv_win_cntrl.sv
// Directed bench for conv_win_cntrl with K=3, MAX_W=8, MAX_H=8.
// Each beat is driven on the falling edge and checked 1 time unit after the rising edge.
// Expected error flag depends on CONV_WIN_CNTRL_LINE_CHECK_EN.
module tb_conv_win_cntrl;

  localparam int K  = 3;
  localparam int PW = 8;
  localparam int MW = 8;
  localparam int MH = 8;
`ifdef CONV_WIN_CNTRL_LINE_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic        clk;
  logic        arst_n;
  logic        vld, sof, eol;
  logic [7:0]  dat;
  logic        pos_vld;
  logic [7:0]  pos;
  logic        nl;
  logic [2:0]  we, re;
  logic [7:0]  lb0;
  logic        err;

  int          errs   = 0;
  int          checks = 0;
  logic [7:0]  last_dat;
  logic [7:0]  seq;
  bit          exp_err;
  string       phase;

  conv_win_cntrl #(.K(K), .PIXEL_W(PW), .MAX_W(MW), .MAX_H(MH)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .intf_vld_i (vld),
    .intf_sof_i (sof),
    .intf_eol_i (eol),
    .intf_dat_i (dat),
    .pos_vld_o  (pos_vld),
    .pos_o      (pos),
    .lbx_nl_o   (nl),
    .lbx_we_o   (we),
    .lbx_re_o   (re),
    .lb0_dat_o  (lb0),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_pos_vld", pos_vld, 0);
    chk("rst_pos", pos, 0);
    chk("rst_nl", nl, 0);
    chk("rst_we", we, 0);
    chk("rst_re", re, 0);
    chk("rst_dat", lb0, 0);
    chk("rst_err", err, 0);
  endtask

  // One clock of stimulus; r/c are the hand-derived row/col of the beat.
  task automatic beat(input bit v, input bit s, input bit e,
                      input int r, input int c, input logic [2:0] xwe);
    logic [2:0] xre;
    logic [7:0] xpos;
    bit         xpv;
    @(negedge clk);
    seq = seq + 8'h1d;
    vld = v; sof = s; eol = e; dat = seq;
    if (v) last_dat = seq;
    @(posedge clk);
    #1;
    xre  = (r == 0) ? 3'b000 : (r == 1) ? 3'b001 : ~xwe;
    xpv  = (r >= 2) && (c >= 2);
    xpos = {r[2:0], c[2:0], (c == 2), e};
    if (v) begin
      chk("we", we, xwe);
      chk("re", re, xre);
      chk("pos_vld", pos_vld, xpv);
      chk("pos", pos, xpos);
      chk("nl", nl, e);
    end else begin
      chk("idle_we", we, 0);
      chk("idle_re", re, 0);
      chk("idle_pos_vld", pos_vld, 0);
      chk("idle_nl", nl, 0);
    end
    chk("dat", lb0, last_dat);
    chk("err", err, exp_err & LC);
  endtask

  initial begin
    vld = 0; sof = 0; eol = 0; dat = 0; seq = 0; last_dat = 0; exp_err = 0;
    arst_n = 1'b1;
    phase = "reset";
    #2 arst_n = 1'b0;
    #1 chk_zero();
    @(negedge clk);
    arst_n = 1'b1;

    // 4x4 frame, continuous valid
    phase = "frame4x4";
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        beat(1, (r == 0 && c == 0), (c == 3), r, c, 3'b001 << (r % 3));

    // asynchronous reset in the middle of a line
    phase = "midreset";
    beat(1, 1, 0, 0, 0, 3'b001);
    beat(1, 0, 0, 0, 1, 3'b001);
    #1;
    arst_n = 1'b0; vld = 0; sof = 0; eol = 0;
    last_dat = 0;
    #1 chk_zero();
    @(negedge clk);
    arst_n = 1'b1;
    beat(1, 0, 1, 0, 0, 3'b001);
    beat(1, 0, 0, 1, 0, 3'b010);

    // single-pixel line (sof & eol) then a 3-pixel line
    phase = "sofeol";
    beat(1, 1, 1, 0, 0, 3'b001);
    beat(1, 0, 0, 1, 0, 3'b010);
    beat(1, 0, 0, 1, 1, 3'b010);
    exp_err = 1;
    beat(1, 0, 1, 1, 2, 3'b010);

    // sof arrives at row2 col1: frame restarts, no stale window
    phase = "sofmid";
    exp_err = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        beat(1, (r == 0 && c == 0), (c == 3), r, c, 3'b001 << r);
    beat(1, 0, 0, 2, 0, 3'b100);
    beat(1, 0, 0, 2, 1, 3'b100);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        beat(1, (r == 0 && c == 0), (c == 2), r, c, 3'b001 << r);

    // valid gaps around an eol
    phase = "gaps";
    beat(1, 1, 0, 0, 0, 3'b001);
    beat(0, 0, 0, 0, 0, 3'b000);
    beat(1, 0, 0, 0, 1, 3'b001);
    beat(0, 0, 1, 0, 0, 3'b000);
    beat(1, 0, 1, 0, 2, 3'b001);
    beat(0, 1, 0, 0, 0, 3'b000);
    beat(1, 0, 0, 1, 0, 3'b010);
    beat(0, 0, 0, 0, 0, 3'b000);
    beat(1, 0, 0, 1, 1, 3'b010);

    // line-length check: row0 width 4, row1 ends at col 2
    phase = "linechk";
    for (int c = 0; c < 4; c++)
      beat(1, (c == 0), (c == 3), 0, c, 3'b001);
    beat(1, 0, 0, 1, 0, 3'b010);
    beat(1, 0, 0, 1, 1, 3'b010);
    exp_err = 1;
    beat(1, 0, 1, 1, 2, 3'b010);
    beat(0, 0, 0, 0, 0, 3'b000);
    beat(1, 0, 0, 2, 0, 3'b100);

    // column saturation at MAX_W-1 on an over-long line
    phase = "colsat";
    for (int i = 0; i < 10; i++) begin
      exp_err = (i >= 7);
      beat(1, (i == 0), (i == 9), 0, (i > 7) ? 7 : i, 3'b001);
    end

    // row saturation at MAX_H-1 with one-pixel lines
    phase = "rowsat";
    exp_err = 0;
    for (int i = 0; i < 9; i++)
      beat(1, (i == 0), 1, (i > 7) ? 7 : i, 0, 3'b001 << (i % 3));
    beat(0, 0, 0, 0, 0, 3'b000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
